// File: rtl/ibex_tlul_arb_pkg.sv
// Shared types for the Ibex instruction/data TL-UL host arbiter.
// The TL-UL structs are a compact local rendition of the bus fields the arbiter carries.
package ibex_tlul_arb_pkg;

    localparam int NumHosts = 2;
    localparam int TL_AIW   = 8;
    localparam int TL_AW    = 32;
    localparam int TL_DW    = 32;
    localparam int TL_DBW   = TL_DW / 8;
    localparam int TL_SZW   = 2;
    localparam int TL_DIW   = 1;
    localparam int TL_UW    = 16;

    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_idx_e;

    typedef enum logic {
        ArbFree   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_UW-1:0]  a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_UW-1:0]  d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/ibex_tlul_arb_cnt.sv
// Per-host outstanding-transaction counter: saturates at MaxCnt, never wraps below zero,
// and latches a sticky underflow flag when a response arrives with nothing outstanding.
module ibex_tlul_arb_cnt #(
    parameter int MaxCnt = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           inc_i,
    input  logic                           dec_i,
    output logic [$clog2(MaxCnt+1)-1:0]    cnt_o,
    output logic                           at_max_o,
    output logic                           underflow_o
);

    localparam int CW = $clog2(MaxCnt + 1);
    localparam logic [CW-1:0] MaxC = CW'(MaxCnt);

    logic [CW-1:0] r_cnt;
    logic          r_uflow;
    logic          w_zero;
    logic          w_dec_ok;
    logic          w_inc_ok;

    assign w_zero   = (r_cnt == '0);
    assign w_dec_ok = dec_i && !w_zero;
    // an increment at max is only legal when a decrement lands in the same cycle
    assign w_inc_ok = inc_i && ((r_cnt != MaxC) || w_dec_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_uflow <= 1'b0;
        end else begin
            if (w_inc_ok && !w_dec_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec_ok && !w_inc_ok) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (dec_i && w_zero) begin
                r_uflow <= 1'b1;
            end
        end
    end

    assign cnt_o       = r_cnt;
    assign at_max_o    = (r_cnt == MaxC);
    assign underflow_o = r_uflow;

endmodule

// File: rtl/ibex_tlul_host_arb.sv
// Merges the Ibex instruction and data TL-UL hosts onto one crossbar port: round-robin A-channel
// arbitration with source tagging, D-channel routing by tag, and per-host outstanding limits.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ArbFree   | no request pending; winner chosen fresh from eligible hosts
//   ArbLocked | winner presented but not accepted; held until A handshake
module ibex_tlul_host_arb
    import ibex_tlul_arb_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter bit InitPrioData   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  tl_h2d_t [NumHosts-1:0]   tl_h_i,
    output tl_d2h_t [NumHosts-1:0]   tl_h_o,
    output tl_h2d_t                  tl_d_o,
    input  tl_d2h_t                  tl_d_i,
    output logic                     idle_o,
    output logic                     rsp_err_o
);

    localparam int CW = $clog2(MaxOutstanding + 1);

    arb_state_e          r_state, w_state_nxt;
    host_idx_e           r_lock_host, w_lock_host_nxt;
    host_idx_e           r_prio, w_prio_nxt;
    logic                r_run;
    host_idx_e           w_win;
    logic                w_a_valid;
    logic                w_a_hs;
    logic                w_d_host;
    logic                w_d_ready;
    logic                w_d_hs;
    logic [NumHosts-1:0] w_elig, w_inc, w_dec, w_at_max, w_uflow;
    logic [CW-1:0]       w_cnt [NumHosts];

    // keeps every handshake output low until the first clock edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run       <= 1'b0;
            r_state     <= ArbFree;
            r_lock_host <= HostInstr;
            r_prio      <= InitPrioData ? HostData : HostInstr;
        end else begin
            r_run       <= 1'b1;
            r_state     <= w_state_nxt;
            r_lock_host <= w_lock_host_nxt;
            r_prio      <= w_prio_nxt;
        end
    end

    always_comb begin
        w_elig = '0;
        for (int h = 0; h < NumHosts; h++) begin
            w_elig[h] = r_run && tl_h_i[h].a_valid && !w_at_max[h];
        end
    end

    // r_prio names the host that wins the next tie, i.e. the one that did not win last
    always_comb begin
        w_win     = r_prio;
        w_a_valid = 1'b0;
        if (r_state == ArbLocked) begin
            w_win     = r_lock_host;
            w_a_valid = r_run && tl_h_i[r_lock_host].a_valid;
        end else begin
            case (w_elig)
                2'b01:   begin w_win = HostInstr; w_a_valid = 1'b1; end
                2'b10:   begin w_win = HostData;  w_a_valid = 1'b1; end
                2'b11:   begin w_win = r_prio;    w_a_valid = 1'b1; end
                default: begin w_win = r_prio;    w_a_valid = 1'b0; end
            endcase
        end
    end

    assign w_a_hs    = w_a_valid && tl_d_i.a_ready;
    assign w_d_host  = tl_d_i.d_source[0];
    assign w_d_ready = r_run && tl_h_i[w_d_host].d_ready;
    assign w_d_hs    = tl_d_i.d_valid && w_d_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_host_nxt = r_lock_host;
        w_prio_nxt      = r_prio;
        if (w_a_hs) begin
            w_state_nxt = ArbFree;
            w_prio_nxt  = (w_win == HostData) ? HostInstr : HostData;
        end else if (w_a_valid) begin
            w_state_nxt     = ArbLocked;
            w_lock_host_nxt = w_win;
        end
    end

    always_comb begin
        tl_d_o          = tl_h_i[w_win];
        tl_d_o.a_valid  = w_a_valid;
        tl_d_o.a_source = {tl_h_i[w_win].a_source[TL_AIW-2:0], w_win};
        tl_d_o.d_ready  = w_d_ready;
        for (int h = 0; h < NumHosts; h++) begin
            tl_h_o[h]          = tl_d_i;
            tl_h_o[h].d_source = {1'b0, tl_d_i.d_source[TL_AIW-1:1]};
            tl_h_o[h].d_valid  = r_run && tl_d_i.d_valid && (w_d_host == 1'(h));
            tl_h_o[h].a_ready  = w_a_valid && (w_win == 1'(h)) && tl_d_i.a_ready;
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int h = 0; h < NumHosts; h++) begin
            w_inc[h] = w_a_hs && (w_win == 1'(h));
            w_dec[h] = w_d_hs && (w_d_host == 1'(h));
        end
    end

    for (genvar h = 0; h < NumHosts; h++) begin : g_host
        ibex_tlul_arb_cnt #(
            .MaxCnt (MaxOutstanding)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (w_inc[h]),
            .dec_i       (w_dec[h]),
            .cnt_o       (w_cnt[h]),
            .at_max_o    (w_at_max[h]),
            .underflow_o (w_uflow[h])
        );

        // the source MSB is consumed by the host tag shift
        a_src_msb_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
            tl_h_i[h].a_valid |-> !tl_h_i[h].a_source[TL_AIW-1]);
    end

    assign idle_o    = (w_cnt[0] == '0) && (w_cnt[1] == '0);
    assign rsp_err_o = |w_uflow;

endmodule

// File: tb/tb_ibex_tlul_host_arb.sv
// Directed bench for ibex_tlul_host_arb: arbitration, locking, routing, limits and error flag.
module tb_ibex_tlul_host_arb;
    import ibex_tlul_arb_pkg::*;

    logic                   clk;
    logic                   rst_n;
    tl_h2d_t [NumHosts-1:0] h_i;
    tl_d2h_t [NumHosts-1:0] h_o;
    tl_h2d_t                d_o;
    tl_d2h_t                d_i;
    logic                   idle;
    logic                   err;

    int n_assert = 0;
    int n_fail   = 0;

    ibex_tlul_host_arb #(
        .MaxOutstanding (2),
        .InitPrioData   (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tl_h_i    (h_i),
        .tl_h_o    (h_o),
        .tl_d_o    (d_o),
        .tl_d_i    (d_i),
        .idle_o    (idle),
        .rsp_err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv_a(input int h, input logic v, input logic [7:0] src, input logic [31:0] addr);
        h_i[h].a_valid   = v;
        h_i[h].a_source  = src;
        h_i[h].a_address = addr;
    endtask

    task automatic drv_d(input logic v, input logic [7:0] src, input logic [31:0] data);
        d_i.d_valid  = v;
        d_i.d_source = src;
        d_i.d_data   = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        h_i   = '0;
        d_i   = '0;
        rst_n = 1'b0;
        // requests and responses present during reset must not leak through
        h_i[0].a_valid = 1'b1;
        h_i[1].a_valid = 1'b1;
        h_i[0].d_ready = 1'b1;
        h_i[1].d_ready = 1'b1;
        h_i[1].a_user  = 16'hBEEF;
        d_i.a_ready    = 1'b1;
        d_i.d_valid    = 1'b1;
        d_i.d_user     = 16'h1234;
        #3;
        chk("rst_a_valid", 32'(d_o.a_valid), 32'h0);
        chk("rst_d_ready", 32'(d_o.d_ready), 32'h0);
        chk("rst_a_ready0", 32'(h_o[0].a_ready), 32'h0);
        chk("rst_a_ready1", 32'(h_o[1].a_ready), 32'h0);
        chk("rst_d_valid0", 32'(h_o[0].d_valid), 32'h0);
        chk("rst_d_valid1", 32'(h_o[1].d_valid), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        tick();
        tick();
        drv_a(0, 1'b0, 8'h00, 32'h0);
        drv_a(1, 1'b0, 8'h00, 32'h0);
        drv_d(1'b0, 8'h00, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // instruction host alone: three reads, third stalls at the limit of two
        drv_a(0, 1'b1, 8'h00, 32'h100);
        settle();
        chk("t1_a0_valid", 32'(d_o.a_valid), 32'h1);
        chk("t1_a0_src", 32'(d_o.a_source), 32'h00);
        chk("t1_a0_addr", d_o.a_address, 32'h100);
        chk("t1_a0_rdy", 32'(h_o[0].a_ready), 32'h1);
        chk("t1_a0_lose_rdy", 32'(h_o[1].a_ready), 32'h0);
        tick();
        drv_a(0, 1'b1, 8'h01, 32'h104);
        settle();
        chk("t1_a1_src", 32'(d_o.a_source), 32'h02);
        tick();
        drv_a(0, 1'b1, 8'h02, 32'h108);
        settle();
        chk("t1_a2_stall_valid", 32'(d_o.a_valid), 32'h0);
        chk("t1_a2_stall_rdy", 32'(h_o[0].a_ready), 32'h0);
        chk("t1_busy", 32'(idle), 32'h0);
        tick();
        settle();
        chk("t1_a2_stall2", 32'(d_o.a_valid), 32'h0);
        drv_d(1'b1, 8'h00, 32'hD0);
        settle();
        chk("t1_d_valid0", 32'(h_o[0].d_valid), 32'h1);
        chk("t1_d_src0", 32'(h_o[0].d_source), 32'h00);
        chk("t1_d_data0", h_o[0].d_data, 32'hD0);
        chk("t1_d_valid1", 32'(h_o[1].d_valid), 32'h0);
        chk("t1_d_ready", 32'(d_o.d_ready), 32'h1);
        chk("t1_no_lookahead", 32'(d_o.a_valid), 32'h0);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t1_a2_valid", 32'(d_o.a_valid), 32'h1);
        chk("t1_a2_src", 32'(d_o.a_source), 32'h04);
        chk("t1_a2_addr", d_o.a_address, 32'h108);
        tick();
        drv_a(0, 1'b0, 8'h00, 32'h0);
        drv_d(1'b1, 8'h00, 32'hD1);
        tick();
        drv_d(1'b1, 8'h02, 32'hD2);
        settle();
        chk("t1_d_src1", 32'(h_o[0].d_source), 32'h01);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t1_idle", 32'(idle), 32'h1);

        // both hosts every cycle: data wins first tie, then strict alternation
        drv_a(0, 1'b1, 8'h03, 32'h400);
        drv_a(1, 1'b1, 8'h05, 32'h500);
        settle();
        chk("t2_w0_src", 32'(d_o.a_source), 32'h0B);
        chk("t2_w0_user", 32'(d_o.a_user), 32'hBEEF);
        chk("t2_w0_rdy1", 32'(h_o[1].a_ready), 32'h1);
        chk("t2_w0_rdy0", 32'(h_o[0].a_ready), 32'h0);
        tick();
        settle();
        chk("t2_w1_src", 32'(d_o.a_source), 32'h06);
        chk("t2_w1_addr", d_o.a_address, 32'h400);
        chk("t2_w1_rdy0", 32'(h_o[0].a_ready), 32'h1);
        tick();
        settle();
        chk("t2_w2_src", 32'(d_o.a_source), 32'h0B);
        tick();
        settle();
        chk("t2_w3_src", 32'(d_o.a_source), 32'h06);
        tick();
        settle();
        chk("t2_both_full", 32'(d_o.a_valid), 32'h0);
        drv_a(0, 1'b0, 8'h00, 32'h0);
        drv_a(1, 1'b0, 8'h00, 32'h0);
        drv_d(1'b1, 8'h01, 32'h11);
        settle();
        chk("t2_d_valid1", 32'(h_o[1].d_valid), 32'h1);
        chk("t2_d_src1", 32'(h_o[1].d_source), 32'h00);
        chk("t2_d_user1", 32'(h_o[1].d_user), 32'h1234);
        chk("t2_d_valid0", 32'(h_o[0].d_valid), 32'h0);
        tick();
        drv_d(1'b1, 8'h03, 32'h13);
        settle();
        chk("t2_d_src1b", 32'(h_o[1].d_source), 32'h01);
        tick();
        h_i[0].d_ready = 1'b0;
        drv_d(1'b1, 8'h00, 32'h20);
        settle();
        chk("t2_bp_dready", 32'(d_o.d_ready), 32'h0);
        chk("t2_bp_dvalid0", 32'(h_o[0].d_valid), 32'h1);
        tick();
        h_i[0].d_ready = 1'b1;
        settle();
        chk("t2_dready", 32'(d_o.d_ready), 32'h1);
        tick();
        drv_d(1'b1, 8'h02, 32'h22);
        settle();
        chk("t2_busy", 32'(idle), 32'h0);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t2_idle", 32'(idle), 32'h1);
        chk("t2_err", 32'(err), 32'h0);

        // data gets stuck behind a_ready=0; instruction must not preempt the lock
        drv_a(1, 1'b1, 8'h00, 32'h200);
        settle();
        chk("t3_pre_src", 32'(d_o.a_source), 32'h01);
        tick();
        d_i.a_ready = 1'b0;
        drv_a(1, 1'b1, 8'h01, 32'h204);
        settle();
        chk("t3_lock_valid", 32'(d_o.a_valid), 32'h1);
        chk("t3_lock_src", 32'(d_o.a_source), 32'h03);
        chk("t3_lock_rdy1", 32'(h_o[1].a_ready), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv_a(0, 1'b1, 8'h00, 32'h300);
            settle();
            chk("t3_held_src", 32'(d_o.a_source), 32'h03);
            chk("t3_held_addr", d_o.a_address, 32'h204);
            chk("t3_held_rdy0", 32'(h_o[0].a_ready), 32'h0);
            tick();
        end
        d_i.a_ready = 1'b1;
        settle();
        chk("t3_rel_src", 32'(d_o.a_source), 32'h03);
        chk("t3_rel_rdy1", 32'(h_o[1].a_ready), 32'h1);
        chk("t3_rel_rdy0", 32'(h_o[0].a_ready), 32'h0);
        tick();
        drv_a(1, 1'b0, 8'h00, 32'h0);
        settle();
        chk("t3_instr_src", 32'(d_o.a_source), 32'h00);
        chk("t3_instr_addr", d_o.a_address, 32'h300);
        chk("t3_instr_rdy", 32'(h_o[0].a_ready), 32'h1);
        tick();
        drv_a(0, 1'b0, 8'h00, 32'h0);

        // data: cnt=2 -> 1, then A and D together must leave it at 1
        drv_d(1'b1, 8'h01, 32'h31);
        tick();
        drv_d(1'b1, 8'h03, 32'h33);
        drv_a(1, 1'b1, 8'h02, 32'h208);
        settle();
        chk("t5_both_arez", 32'(h_o[1].a_ready), 32'h1);
        chk("t5_both_dv", 32'(h_o[1].d_valid), 32'h1);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        drv_a(1, 1'b1, 8'h03, 32'h20C);
        settle();
        chk("t5_cnt1_open", 32'(d_o.a_valid), 32'h1);
        chk("t5_cnt1_src", 32'(d_o.a_source), 32'h07);
        tick();
        settle();
        chk("t5_cnt2_full", 32'(d_o.a_valid), 32'h0);
        drv_a(1, 1'b0, 8'h00, 32'h0);
        drv_d(1'b1, 8'h01, 32'h41);
        tick();
        tick();
        drv_d(1'b1, 8'h00, 32'h42);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t5_idle", 32'(idle), 32'h1);
        chk("t5_err", 32'(err), 32'h0);

        // response for data with nothing outstanding: forwarded, and error sticks
        drv_d(1'b1, 8'h01, 32'h66);
        settle();
        chk("t6_fwd", 32'(h_o[1].d_valid), 32'h1);
        chk("t6_err_pre", 32'(err), 32'h0);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t6_err_set", 32'(err), 32'h1);
        tick();
        tick();
        settle();
        chk("t6_err_sticky", 32'(err), 32'h1);
        chk("t6_idle", 32'(idle), 32'h1);

        // reset with a transaction outstanding, then a late response
        drv_a(0, 1'b1, 8'h00, 32'h700);
        tick();
        drv_a(0, 1'b0, 8'h00, 32'h0);
        settle();
        chk("t7_busy", 32'(idle), 32'h0);
        rst_n = 1'b0;
        drv_a(0, 1'b1, 8'h01, 32'h704);
        settle();
        chk("t7_rst_idle", 32'(idle), 32'h1);
        chk("t7_rst_err", 32'(err), 32'h0);
        chk("t7_rst_avalid", 32'(d_o.a_valid), 32'h0);
        tick();
        drv_a(0, 1'b0, 8'h00, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        drv_d(1'b1, 8'h00, 32'h77);
        settle();
        chk("t7_late_err_pre", 32'(err), 32'h0);
        tick();
        drv_d(1'b0, 8'h00, 32'h0);
        settle();
        chk("t7_late_err", 32'(err), 32'h1);
        chk("t7_late_idle", 32'(idle), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
